// File: rtl/fb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_pkg : framebuffer geometry, page-swap state type and page-base helper
// rev 1.0
// ---------------------------------------------------------------------------
package fb_pkg;

  localparam int RES_X      = 320;
  localparam int RES_Y      = 240;
  localparam int PAGE_BYTES = RES_X * RES_Y / 8;
  localparam int MEM_AW     = 15;

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  function automatic int unsigned page_base(input logic page, input int unsigned page_bytes);
    return page ? page_bytes : 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_page_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_page_ctrl : front/back page swap FSM, swap applied only on frame_start
// rev 1.0
// ---------------------------------------------------------------------------
module fb_page_ctrl
  import fb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic swap_req,
  input  logic frame_start,
  output logic front_page,
  output logic swap_pending
);

  swap_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SWAP_IDLE;
      front_page   <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      case (state)
        SWAP_IDLE: begin
          // a frame_start in the same cycle does not apply this request
          if (swap_req) begin
            state        <= SWAP_PENDING;
            swap_pending <= 1'b1;
          end
        end
        SWAP_PENDING: begin
          if (frame_start) begin
            state        <= SWAP_IDLE;
            swap_pending <= 1'b0;
            front_page   <= ~front_page;
          end
        end
        default: begin
          state        <= SWAP_IDLE;
          swap_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_arbiter : shares the framebuffer RAM between scanout and host, two pages
// rev 1.0
// ---------------------------------------------------------------------------
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int RES_X  = fb_pkg::RES_X,
  parameter int RES_Y  = fb_pkg::RES_Y,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = fb_pkg::MEM_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_valid,
  output logic [7:0]        scan_data,
  input  logic              frame_start,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [7:0]        host_rdata,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              front_page,
  output logic              err_oob,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int unsigned     PAGE_SZ  = RES_X * RES_Y / 8;
  localparam logic [ADDR_W-1:0] PAGE_LIM = ADDR_W'(PAGE_SZ);

  logic scan_oob;
  logic host_oob;

  assign scan_oob = (scan_addr >= PAGE_LIM);
  assign host_oob = (host_addr >= PAGE_LIM);

  fb_page_ctrl u_page_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .swap_req     (swap_req),
    .frame_start  (frame_start),
    .front_page   (front_page),
    .swap_pending (swap_pending)
  );

  // Out-of-range offsets collapse to offset 0 so the RAM never sees the other page
  always_comb begin
    host_gnt  = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (scan_req) begin
      mem_addr = MEM_AW'(page_base(front_page, PAGE_SZ) +
                         (scan_oob ? 32'd0 : 32'(scan_addr)));
    end else if (host_req && !swap_pending) begin
      host_gnt  = 1'b1;
      mem_addr  = MEM_AW'(page_base(~front_page, PAGE_SZ) +
                          (host_oob ? 32'd0 : 32'(host_addr)));
      mem_we    = host_we & ~host_oob & rst_n;
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_valid  <= 1'b0;
      host_rvalid <= 1'b0;
      err_oob     <= 1'b0;
    end else begin
      scan_valid  <= scan_req;
      host_rvalid <= host_gnt & ~host_we;
      if ((scan_req && scan_oob) || (host_gnt && host_oob))
        err_oob <= 1'b1;
    end
  end

  assign scan_data  = mem_rdata;
  assign host_rdata = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fb_arbiter : randomized traffic against a behavioural framebuffer model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_fb_arbiter;

  localparam int PB = 9600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_req, frame_start, host_req, host_we, swap_req;
  logic [15:0] scan_addr, host_addr;
  logic [7:0]  host_wdata;
  logic        scan_valid, host_gnt, host_rvalid, swap_pending, front_page, err_oob, mem_we;
  logic [7:0]  scan_data, host_rdata, mem_wdata, mem_rdata;
  logic [14:0] mem_addr;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:32767];
  logic [7:0] mm  [0:2*PB-1];

  fb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_valid(scan_valid), .scan_data(scan_data),
    .frame_start(frame_start),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .swap_req(swap_req), .swap_pending(swap_pending), .front_page(front_page), .err_oob(err_oob),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // synchronous-read RAM behind the arbiter
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int   m_front, m_pend, m_err, m_sv, m_hv, m_hknown;
  int   m_sdata, m_hdata;

  initial begin
    int e_addr, e_we, e_gnt, chk_addr, s_oob, h_oob, off;
    m_front = 0; m_pend = 0; m_err = 0; m_sv = 0; m_hv = 0; m_hknown = 0;
    m_sdata = 0; m_hdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_front = 0; m_pend = 0; m_err = 0; m_sv = 0; m_hv = 0;
      end
      s_oob    = (int'(scan_addr) >= PB);
      h_oob    = (int'(host_addr) >= PB);
      e_gnt    = (!scan_req && host_req && !m_pend) ? 1 : 0;
      e_addr   = 0;
      e_we     = 0;
      chk_addr = 1;
      if (scan_req) begin
        e_addr = m_front * PB + (s_oob ? 0 : int'(scan_addr));
      end else if (e_gnt != 0) begin
        if (h_oob) chk_addr = 0;
        else e_addr = (1 - m_front) * PB + int'(host_addr);
        e_we = (host_we && !h_oob && rst_n) ? 1 : 0;
      end
      chk("host_gnt", host_gnt, e_gnt);
      chk("mem_we", mem_we, e_we);
      if (chk_addr != 0) chk("mem_addr", mem_addr, e_addr);
      if (e_we != 0) chk("mem_wdata", mem_wdata, host_wdata);
      chk("scan_valid", scan_valid, m_sv);
      chk("host_rvalid", host_rvalid, m_hv);
      chk("swap_pending", swap_pending, m_pend);
      chk("front_page", front_page, m_front);
      chk("err_oob", err_oob, m_err);
      if (m_sv != 0) chk("scan_data", scan_data, m_sdata);
      if (m_hv != 0 && m_hknown != 0) chk("host_rdata", host_rdata, m_hdata);

      @(posedge clk);
      if (rst_n) begin
        m_sv = 0; m_hv = 0;
        if (scan_req) begin
          m_sv    = 1;
          off     = s_oob ? 0 : int'(scan_addr);
          m_sdata = mm[m_front * PB + off];
          if (s_oob) m_err = 1;
        end else if (e_gnt != 0) begin
          if (h_oob) m_err = 1;
          if (!host_we) begin
            m_hv     = 1;
            m_hknown = h_oob ? 0 : 1;
            if (!h_oob) m_hdata = mm[(1 - m_front) * PB + int'(host_addr)];
          end else if (!h_oob) begin
            mm[(1 - m_front) * PB + int'(host_addr)] = host_wdata;
          end
        end
        if (m_pend == 0) begin
          if (swap_req) m_pend = 1;
        end else if (frame_start) begin
          m_pend  = 0;
          m_front = 1 - m_front;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int granted_last;
    for (int i = 0; i < 32768; i++) ram[i] = 8'($urandom);
    ram[16] = 8'hA5;
    for (int i = 0; i < 2*PB; i++) mm[i] = ram[i];
    rst_n = 1'b0; scan_req = 0; scan_addr = 0; frame_start = 0; host_req = 0;
    host_we = 0; host_addr = 0; host_wdata = 0; swap_req = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset front_page", front_page, 0);
    chk("reset swap_pending", swap_pending, 0);
    chk("reset err_oob", err_oob, 0);

    // scan read from front page 0
    scan_req = 1; scan_addr = 16'h0010; #1;
    chk("scan mem_addr", mem_addr, 16);
    tick(); scan_req = 0; #1;
    chk("scan valid", scan_valid, 1);
    chk("scan data", scan_data, 8'hA5);

    // scan beats host; host lands on back page next cycle
    scan_req = 1; host_req = 1; host_we = 1; host_addr = 5; host_wdata = 8'h3C; #1;
    chk("conflict gnt", host_gnt, 0);
    tick(); scan_req = 0; #1;
    chk("host gnt", host_gnt, 1);
    chk("host we", mem_we, 1);
    chk("host addr", mem_addr, 9605);
    chk("host wdata", mem_wdata, 8'h3C);
    tick(); host_req = 0;

    // swap with host blocked while pending
    swap_req = 1; tick(); swap_req = 0;
    host_req = 1; host_we = 1; host_addr = 0; host_wdata = 8'h77; #1;
    chk("pending gnt", host_gnt, 0);
    chk("pending flag", swap_pending, 1);
    repeat (8) tick();
    frame_start = 1; #1;
    chk("fs cycle front", front_page, 0);
    tick(); frame_start = 0; #1;
    chk("swapped front", front_page, 1);
    chk("swapped pending", swap_pending, 0);
    chk("swapped host addr", mem_addr, 0);
    tick(); host_req = 0; scan_req = 1; scan_addr = 3; #1;
    chk("swapped scan addr", mem_addr, 9603);
    tick(); scan_req = 0;

    // swap_req coincident with frame_start
    swap_req = 1; frame_start = 1; tick(); swap_req = 0; frame_start = 0; #1;
    chk("simul pending", swap_pending, 1);
    chk("simul front", front_page, 1);
    repeat (2) tick();
    frame_start = 1; tick(); frame_start = 0; #1;
    chk("simul applied", front_page, 0);

    // out-of-range host write
    host_req = 1; host_we = 1; host_addr = 16'd9600; host_wdata = 8'h11; #1;
    chk("oob gnt", host_gnt, 1);
    chk("oob we", mem_we, 0);
    tick(); host_req = 0; #1;
    chk("oob err", err_oob, 1);
    repeat (5) tick();
    chk("oob sticky", err_oob, 1);

    // randomized traffic with one reset in the middle
    granted_last = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        scan_req = 0; host_req = 1; host_we = 1; host_addr = 10; swap_req = 0; frame_start = 0;
        rst_n = 0; #1;
        chk("midrst mem_we", mem_we, 0);
        chk("midrst scan_valid", scan_valid, 0);
        chk("midrst host_rvalid", host_rvalid, 0);
        chk("midrst pending", swap_pending, 0);
        chk("midrst front", front_page, 0);
        chk("midrst err", err_oob, 0);
        tick(); rst_n = 1; host_req = 0; granted_last = 1;
      end
      scan_req  = ($urandom_range(0, 9) < 5);
      scan_addr = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(PB, 65535))
                                               : 16'($urandom_range(0, PB - 1));
      if (!host_req || granted_last != 0) begin
        host_req   = ($urandom_range(0, 2) != 0);
        host_we    = $urandom_range(0, 1) == 1;
        host_addr  = ($urandom_range(0, 29) == 0) ? 16'($urandom_range(PB, 65535))
                                                  : 16'($urandom_range(0, PB - 1));
        host_wdata = 8'($urandom);
      end
      swap_req    = ($urandom_range(0, 29) == 0);
      frame_start = ($urandom_range(0, 19) == 0);
      #1;
      granted_last = host_gnt ? 1 : 0;
      tick();
    end
    scan_req = 0; host_req = 0; swap_req = 0; frame_start = 0;
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
